// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 stream demultiplexer.
//
// One valid/ready input stream is routed beat by beat to output A or B
// according to in_sel (0 = A, 1 = B). Each output owns a 2-entry FIFO, so a
// stalled output only blocks beats addressed to it.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready reflects the FIFO picked by in_sel
//   in_data, in_sel     input payload and route select
//   a_valid/a_ready     output A handshake, a_data = head of FIFO A
//   b_valid/b_ready     output B handshake, b_data = head of FIFO B
//   a_count, b_count    delivered-beat counters (8-bit, wrapping)
//
// Build option: define DEMUX_CNT_EN to build the delivered-beat counters;
// otherwise a_count and b_count are tied to zero (port list unchanged).

module stream_demux2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sel,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [DW-1:0] a_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [DW-1:0] b_data,
    output logic [7:0]    a_count,
    output logic [7:0]    b_count
);

    logic [DW-1:0] a_mem [2];
    logic [DW-1:0] b_mem [2];
    logic          a_wr, a_rd, b_wr, b_rd;
    logic [1:0]    a_occ, b_occ;

    logic accept, a_push, b_push, a_pop, b_pop;

    // Readiness uses only registered occupancy: a pop in the same cycle
    // never frees space for a push into a full FIFO.
    assign in_ready = in_sel ? (b_occ != 2'd2) : (a_occ != 2'd2);
    assign accept   = in_valid & in_ready;
    assign a_push   = accept & ~in_sel;
    assign b_push   = accept &  in_sel;

    assign a_valid  = (a_occ != 2'd0);
    assign b_valid  = (b_occ != 2'd0);
    assign a_data   = a_mem[a_rd];
    assign b_data   = b_mem[b_rd];
    assign a_pop    = a_valid & a_ready;
    assign b_pop    = b_valid & b_ready;

    // Storage carries no reset; contents are ignored while occupancy is 0.
    always_ff @(posedge clk) begin
        if (rst_n && a_push) a_mem[a_wr] <= in_data;
        if (rst_n && b_push) b_mem[b_wr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_wr  <= 1'b0;
            a_rd  <= 1'b0;
            a_occ <= 2'd0;
            b_wr  <= 1'b0;
            b_rd  <= 1'b0;
            b_occ <= 2'd0;
        end else begin
            if (a_push) a_wr <= ~a_wr;
            if (a_pop)  a_rd <= ~a_rd;
            case ({a_push, a_pop})
                2'b10:   a_occ <= a_occ + 2'd1;
                2'b01:   a_occ <= a_occ - 2'd1;
                default: a_occ <= a_occ;
            endcase

            if (b_push) b_wr <= ~b_wr;
            if (b_pop)  b_rd <= ~b_rd;
            case ({b_push, b_pop})
                2'b10:   b_occ <= b_occ + 2'd1;
                2'b01:   b_occ <= b_occ - 2'd1;
                default: b_occ <= b_occ;
            endcase
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] a_cnt_q, b_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt_q <= 8'd0;
            b_cnt_q <= 8'd0;
        end else begin
            if (a_pop) a_cnt_q <= a_cnt_q + 8'd1;
            if (b_pop) b_cnt_q <= b_cnt_q + 8'd1;
        end
    end

    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;
`else
    assign a_count = 8'd0;
    assign b_count = 8'd0;
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Directed self-checking bench for stream_demux2. Inputs change 1 time unit
// after each rising edge; outputs are checked in the remainder of the cycle.

module tb_stream_demux2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_data;
    logic [7:0] a_count;
    logic [7:0] b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_demux2 #(.DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
        in_sel = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_sel0 got=%b exp=1", in_ready); end
        in_sel = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_sel1 got=%b exp=1", in_ready); end
        checks++; if (a_count !== 8'd0) begin failures++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
        checks++; if (b_count !== 8'd0) begin failures++; $display("FAIL reset_b_count got=%0d exp=0", b_count); end
        tick();
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b%b exp=00", a_valid, b_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a, exp_b;
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
        tick();
        in_data = 8'h22; in_sel = 1'b1;
        checks++; if (a_valid !== 1'b1 || a_data !== 8'h11) begin failures++; $display("FAIL b2b_a11 got=%b/%h exp=1/11", a_valid, a_data); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL b2b_b_idle got=%b exp=0", b_valid); end
        tick();
        in_data = 8'h33; in_sel = 1'b0;
        checks++; if (b_valid !== 1'b1 || b_data !== 8'h22) begin failures++; $display("FAIL b2b_b22 got=%b/%h exp=1/22", b_valid, b_data); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL b2b_a_drained got=%b exp=0", a_valid); end
        tick();
        in_valid = 1'b0;
        exp_a = 8'h33;
        checks++; if (a_valid !== 1'b1 || a_data !== exp_a) begin failures++; $display("FAIL b2b_a33 got=%b/%h exp=1/%h", a_valid, a_data, exp_a); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL b2b_b_drained got=%b exp=0", b_valid); end
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL b2b_a_empty got=%b exp=0", a_valid); end
`ifdef DEMUX_CNT_EN
        exp_a = 8'd2; exp_b = 8'd1;
`else
        exp_a = 8'd0; exp_b = 8'd0;
`endif
        checks++; if (a_count !== exp_a) begin failures++; $display("FAIL b2b_a_count got=%0d exp=%0d", a_count, exp_a); end
        checks++; if (b_count !== exp_b) begin failures++; $display("FAIL b2b_b_count got=%0d exp=%0d", b_count, exp_b); end
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_a1 got=%b exp=1", in_ready); end
        tick();
        in_data = 8'hA2; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_a2 got=%b exp=1", in_ready); end
        tick();
        in_data = 8'hA3; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_hold got=%b exp=0", in_ready); end
        checks++; if (a_valid !== 1'b1 || a_data !== 8'hA1) begin failures++; $display("FAIL bp_head_a1 got=%b/%h exp=1/a1", a_valid, a_data); end
        // B is still reachable while A is full.
        in_sel = 1'b1; in_data = 8'hB1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_b got=%b exp=1", in_ready); end
        tick();
        in_sel = 1'b0; in_data = 8'hA3;
        checks++; if (b_valid !== 1'b1 || b_data !== 8'hB1) begin failures++; $display("FAIL bp_b1 got=%b/%h exp=1/b1", b_valid, b_data); end
        // Full FIFO: pop this cycle must not open the input.
        a_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_pop got=%b exp=0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%b exp=1", in_ready); end
        checks++; if (a_valid !== 1'b1 || a_data !== 8'hA2) begin failures++; $display("FAIL bp_a2 got=%b/%h exp=1/a2", a_valid, a_data); end
        tick();
        in_valid = 1'b0;
        checks++; if (a_valid !== 1'b1 || a_data !== 8'hA3) begin failures++; $display("FAIL bp_a3 got=%b/%h exp=1/a3", a_valid, a_data); end
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL bp_a_empty got=%b exp=0", a_valid); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_d;
        a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            exp_d = 8'(i);
            in_data = exp_d; #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
            checks++; if (a_valid !== 1'b1 || a_data !== exp_d) begin failures++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, a_valid, a_data, exp_d); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", a_valid); end
    endtask

    task automatic test_reset_flush();
        a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
        in_data = 8'hC1; tick();
        in_data = 8'hC2; tick();
        checks++; if (a_valid !== 1'b1 || a_data !== 8'hC1) begin failures++; $display("FAIL flush_pre got=%b/%h exp=1/c1", a_valid, a_data); end
        // Reset cycle with a (not accepted) beat presented; make room first is irrelevant.
        rst_n = 1'b0; in_data = 8'hC3;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL flush_a_valid got=%b exp=0", a_valid); end
        checks++; if (a_count !== 8'd0 || b_count !== 8'd0) begin failures++; $display("FAIL flush_counts got=%0d/%0d exp=0/0", a_count, b_count); end
        a_ready = 1'b1;
        tick();
        tick();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%b exp=0", a_valid); end
    endtask

    task automatic test_counter();
        logic [7:0] exp_b;
        b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL cnt_b_drained got=%b exp=0", b_valid); end
`ifdef DEMUX_CNT_EN
        exp_b = 8'd1;
`else
        exp_b = 8'd0;
`endif
        checks++; if (b_count !== exp_b) begin failures++; $display("FAIL cnt_b_wrap got=%0d exp=%0d", b_count, exp_b); end
        checks++; if (a_count !== 8'd0) begin failures++; $display("FAIL cnt_a_zero got=%0d exp=0", a_count); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_stream();
        test_reset_flush();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
